md_unit: RTL and testbench

- Multi-cycle multiply/divide unit with HI/LO registers, placed beside the ALU in the execute stage of the MIPS datapath.
- Consumes the same operands as the ALU: rs value on A, rt value on B.
- Provides HI/LO to the GRF write-back mux for mfhi/mflo.
- Drives Busy so control logic can stall later mult/div/mfhi/mflo/mthi/mtlo instructions.

---
 rtl/md_unit.sv | 208 ++++++++++++++++++++
 tb/tb_md_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : Multi-cycle multiply/divide unit with HI/LO registers for the
//               execute stage of the MIPS datapath. The full result is computed
//               at issue and parked internally. Busy then stays high for a fixed
//               number of cycles, and the result is committed to HI/LO on the
//               final edge.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk    in   1  system clock, rising edge
//   reset  in   1  asynchronous active-low reset
//   MDOp   in   3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//                  7 reserved (none)
//   Abort  in   1  flush of an in-flight op (only when MD_ABORT_EN is defined)
//   A      in  32  rs operand
//   B      in  32  rt operand
//   Busy   out  1  high while a mult/div is in flight
//   HI     out 32  HI register
//   LO     out 32  LO register
// Build option
//   MD_ABORT_EN : adds the Abort input. When it is undefined, every operation
//                 runs to completion.
// ============================================================================
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,   // 1..15
  parameter int unsigned DIV_CYCLES  = 10   // 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MDOp,
`ifdef MD_ABORT_EN
  input  logic        Abort,
`endif
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // The counter is loaded with N-1 at issue, and the op completes on the edge
  // that sees zero. Busy is therefore high for exactly N cycles.
  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, lo_q;
  logic [31:0] res_hi_q, res_lo_q;
  logic        res_we_q;

  logic        w_abort;
  logic        w_is_md;
  logic        w_is_div;
  logic        w_issue;
  logic        w_done;
  logic        w_mthi;
  logic        w_mtlo;

`ifdef MD_ABORT_EN
  assign w_abort = Abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_is_md  = (MDOp == OP_MULT) || (MDOp == OP_MULTU) ||
                    (MDOp == OP_DIV)  || (MDOp == OP_DIVU);
  assign w_is_div = (MDOp == OP_DIV)  || (MDOp == OP_DIVU);

  // --------------------------------------------------------------------------
  // Arithmetic, evaluated from the operands present at the issue edge
  // --------------------------------------------------------------------------
  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  logic               w_sdiv;
  logic               w_a_neg, w_b_neg;
  logic        [31:0] w_mag_a, w_mag_b, w_div_b;
  logic        [31:0] w_q, w_r, w_quo, w_rem;
  logic        [31:0] w_res_hi, w_res_lo;
  logic               w_res_we;

  assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // Signed division is done on magnitudes so that truncation toward zero and
  // the 0x80000000 / -1 case fall out naturally: the magnitude 0x80000000
  // negates back to itself.
  assign w_sdiv  = (MDOp == OP_DIV);
  assign w_a_neg = w_sdiv & A[31];
  assign w_b_neg = w_sdiv & B[31];
  assign w_mag_a = w_a_neg ? (~A + 32'd1) : A;
  assign w_mag_b = w_b_neg ? (~B + 32'd1) : B;
  // Keep the divider away from zero. The result is discarded in that case.
  assign w_div_b = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
  assign w_q     = w_mag_a / w_div_b;
  assign w_r     = w_mag_a % w_div_b;
  assign w_quo   = (w_a_neg ^ w_b_neg) ? (~w_q + 32'd1) : w_q;
  assign w_rem   = w_a_neg ? (~w_r + 32'd1) : w_r;

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    w_res_we = 1'b1;
    case (MDOp)
      OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
      OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
      OP_DIV, OP_DIVU: begin
        w_res_hi = w_rem;
        w_res_lo = w_quo;
        w_res_we = (B != 32'd0);   // divide by zero leaves HI/LO untouched
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_issue) begin
          state_d = S_RUN;
          cnt_d   = w_is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      S_RUN: begin
        if (w_abort || (cnt_q == 4'd0)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output / control decode
  // Any MDOp seen in RUN is ignored. Abort also masks MDOp while in IDLE.
  // --------------------------------------------------------------------------
  always_comb begin
    Busy    = (state_q == S_RUN);
    w_issue = (state_q == S_IDLE) && !w_abort && w_is_md;
    w_mthi  = (state_q == S_IDLE) && !w_abort && (MDOp == OP_MTHI);
    w_mtlo  = (state_q == S_IDLE) && !w_abort && (MDOp == OP_MTLO);
    w_done  = (state_q == S_RUN)  && !w_abort && (cnt_q == 4'd0);
  end

  // --------------------------------------------------------------------------
  // Result staging and HI/LO registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      res_we_q <= 1'b0;
    end else begin
      if (w_issue) begin
        res_hi_q <= w_res_hi;
        res_lo_q <= w_res_lo;
        res_we_q <= w_res_we;
      end
      // Completion happens only in RUN, and mthi/mtlo only in IDLE, so these
      // writes are mutually exclusive.
      if (w_done && res_we_q) begin
        hi_q <= res_hi_q;
        lo_q <= res_lo_q;
      end
      if (w_mthi) hi_q <= A;
      if (w_mtlo) lo_q <= A;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit
// Description : Directed self-checking bench for md_unit (default cycle
//               counts). Covers the MD_ABORT_EN variant when that macro is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  MDOp = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Busy;
  logic [31:0] HI, LO;
`ifdef MD_ABORT_EN
  logic        Abort = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .MDOp  (MDOp),
`ifdef MD_ABORT_EN
    .Abort (Abort),
`endif
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue an op for one cycle, then measure how long Busy stays high.
  // HI is checked to still hold its old value on the last Busy cycle.
  // Optionally drive one extra MDOp on Busy cycle inj_at; it must be ignored.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int inj_at, input logic [2:0] inj_op,
                        input logic [31:0] inj_a);
    logic [31:0] old_hi;
    int n;
    old_hi = HI;
    MDOp = op; A = a; B = b;
    tick();
    MDOp = OP_NONE;
    n = 0;
    while (Busy && n < 40) begin
      n++;
      if (n == exp_n) chk({tag, "_hi_hold"}, HI, old_hi);
      if (n == inj_at) begin
        MDOp = inj_op; A = inj_a;
      end else begin
        MDOp = OP_NONE;
      end
      tick();
    end
    MDOp = OP_NONE;
    chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
    chk({tag, "_hi"}, HI, exp_hi);
    chk({tag, "_lo"}, LO, exp_lo);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    reset = 1'b1;
    tick();
    chk("rel_busy", {31'd0, Busy}, 32'd0);

    // Multiplies
    run_op("mult_m1x2",  OP_MULT,  32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, OP_NONE, 32'd0);
    run_op("multu_m1x2", OP_MULTU, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE, 0, OP_NONE, 32'd0);

    // Divides
    run_op("div_m7_2",   OP_DIV,   32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, OP_NONE, 32'd0);
    run_op("divu_m7_2",  OP_DIVU,  32'hFFFFFFF9, 32'd2, 10, 32'h00000001, 32'h7FFFFFFC, 0, OP_NONE, 32'd0);
    run_op("div_7_m2",   OP_DIV,   32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD, 0, OP_NONE, 32'd0);
    run_op("div_ovf",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, 0, OP_NONE, 32'd0);
    run_op("mult_min2",  OP_MULT,  32'h80000000, 32'h80000000, 5, 32'h40000000, 32'h00000000, 0, OP_NONE, 32'd0);

    // mthi / mtlo, then divide by zero leaves both untouched
    MDOp = OP_MTHI; A = 32'h12345678;
    tick();
    MDOp = OP_NONE;
    chk("mthi_hi", HI, 32'h12345678);
    chk("mthi_lo", LO, 32'h00000000);
    chk("mthi_busy", {31'd0, Busy}, 32'd0);
    MDOp = OP_MTLO; A = 32'h0BADF00D;
    tick();
    MDOp = OP_NONE;
    chk("mtlo_lo", LO, 32'h0BADF00D);
    chk("mtlo_hi", HI, 32'h12345678);
    run_op("divu_by0", OP_DIVU, 32'd7, 32'd0, 10, 32'h12345678, 32'h0BADF00D, 0, OP_NONE, 32'd0);
    run_op("div_by0",  OP_DIV,  32'hFFFFFFF0, 32'd0, 10, 32'h12345678, 32'h0BADF00D, 0, OP_NONE, 32'd0);

    // Ops presented while Busy are ignored
    run_op("mult_inj_mtlo", OP_MULT, 32'd3, 32'd4, 5, 32'h00000000, 32'h0000000C, 2, OP_MTLO, 32'h000000AA);
    run_op("div_inj_mult",  OP_DIVU, 32'd100, 32'd7, 10, 32'h00000002, 32'h0000000E, 4, OP_MULT, 32'd5);

    // Asynchronous reset in the middle of RUN
    MDOp = OP_MTHI; A = 32'hDEADBEEF;
    tick();
    MDOp = OP_DIV; A = 32'd100; B = 32'd3;
    tick();
    MDOp = OP_NONE;
    tick();
    tick();
    chk("pre_rst_busy", {31'd0, Busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, Busy}, 32'd0);
    chk("async_rst_hi", HI, 32'd0);
    chk("async_rst_lo", LO, 32'd0);
    #2 reset = 1'b1;
    tick();
    MDOp = OP_MTHI; A = 32'h00000055;
    tick();
    MDOp = OP_NONE;
    chk("post_rst_mthi", HI, 32'h00000055);
    chk("post_rst_busy", {31'd0, Busy}, 32'd0);

`ifdef MD_ABORT_EN
    // Abort on the 3rd Busy cycle flushes without touching HI/LO
    MDOp = OP_MTLO; A = 32'h00000022;
    tick();
    MDOp = OP_DIV; A = 32'd100; B = 32'd3;
    tick();
    MDOp = OP_NONE;
    tick();
    tick();
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_hi", HI, 32'h00000055);
    chk("abort_lo", LO, 32'h00000022);
    repeat (12) tick();
    chk("abort_late_hi", HI, 32'h00000055);
    chk("abort_late_lo", LO, 32'h00000022);
    // Abort in IDLE suppresses a same-edge mthi
    Abort = 1'b1; MDOp = OP_MTHI; A = 32'h00000099;
    tick();
    Abort = 1'b0; MDOp = OP_NONE;
    chk("abort_idle_hi", HI, 32'h00000055);
    chk("abort_idle_busy", {31'd0, Busy}, 32'd0);
    run_op("mult_after_abort", OP_MULT, 32'd2, 32'd3, 5, 32'h00000000, 32'h00000006, 0, OP_NONE, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
